// File: rtl/lfsr_pkg.sv
// lfsr_pkg: definitions shared by the LFSR generator and the PRBS checker.
//   chk_state_e     - checker FSM state encoding (2 bits)
//   LFSR_WIDTH_DEF  - default LFSR register width
//   LFSR_POLY_DEF   - default tap mask (bit i set => history bit i is a tap)
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEED    = 2'd1,
    ST_LOCKING = 2'd2,
    ST_LOCKED  = 2'd3
  } chk_state_e;

  localparam int unsigned                 LFSR_WIDTH_DEF = 11;
  localparam logic [LFSR_WIDTH_DEF-1:0]   LFSR_POLY_DEF  = 11'b10000000010;

endpackage

// File: rtl/lfsr_checker_win.sv
// lfsr_checker_win: loss-of-lock window for the PRBS checker.
// Counts accepted bits in windows of LOSS_WINDOW; errors inside one window
// are accumulated and a loss pulse is raised on the mismatching bit that
// brings the window count to LOSS_THRESH.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   clear      - restart window and error count (checker entering SEED)
//   acc        - a bit was accepted while LOCKED
//   mis        - the accepted bit mismatched the expected bit
//   loss       - combinational pulse: this bit reaches the threshold
module lfsr_checker_win #(
  parameter int unsigned LOSS_WINDOW = 64,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic acc,
  input  logic mis,
  output logic loss
);

  localparam int unsigned WCW = $clog2(LOSS_WINDOW + 1);
  localparam int unsigned ECW = $clog2(LOSS_THRESH + 1);

  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [ECW-1:0] werr_q, werr_d;

  // Kept independent of clear: the FSM derives clear from loss.
  assign loss = acc && mis && (werr_q == ECW'(LOSS_THRESH - 1));

  always_comb begin
    wcnt_d = wcnt_q;
    werr_d = werr_q;
    if (clear) begin
      wcnt_d = '0;
      werr_d = '0;
    end else if (acc) begin
      if (mis) werr_d = werr_q + ECW'(1);
      if (wcnt_q == WCW'(LOSS_WINDOW - 1)) begin
        wcnt_d = '0;
        werr_d = '0;
      end else begin
        wcnt_d = wcnt_q + WCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
      werr_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      werr_q <= werr_d;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-seeding serial PRBS checker.
// Seeds its history register from the incoming stream, confirms LOCK_COUNT
// consecutive predicted bits, then free-runs and counts mismatches.
// Optional feature macro: LFSR_CHECKER_BIT_CNT_EN builds the 32-bit bit_cnt
// register; otherwise bit_cnt is tied to 0.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   en         - enable; low returns to IDLE holding counters
//   din/din_vld- serial bit and its qualifier
//   resync     - discard lock and re-seed (bit in that cycle discarded)
//   clr        - synchronous clear of err_cnt and bit_cnt
//   locked     - synchronized indication
//   err        - pulse per mismatching bit while locked
//   err_cnt    - saturating mismatch count while locked
//   bit_cnt    - saturating count of bits accepted while locked
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned                 LFSR_WIDTH      = LFSR_WIDTH_DEF,
  parameter logic [LFSR_WIDTH-1:0]       LFSR_POLYNOMIAL = LFSR_WIDTH'(LFSR_POLY_DEF),
  parameter int unsigned                 LOCK_COUNT      = 16,
  parameter int unsigned                 LOSS_WINDOW     = 64,
  parameter int unsigned                 LOSS_THRESH     = 4,
  parameter int unsigned                 ERR_CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     din,
  input  logic                     din_vld,
  input  logic                     resync,
  input  logic                     clr,
  output logic                     locked,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [31:0]              bit_cnt
);

  localparam int unsigned FW = $clog2(LFSR_WIDTH + 1);
  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

  chk_state_e               state_q, state_d;
  logic [LFSR_WIDTH-1:0]    hist_q, hist_d;
  logic [FW-1:0]            fill_q, fill_d;
  logic [MW-1:0]            match_q, match_d;
  logic                     locked_q, locked_d;
  logic                     err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
`ifdef LFSR_CHECKER_BIT_CNT_EN
  logic [31:0]              bit_cnt_q, bit_cnt_d;
`endif

  logic exp_bit, mis, win_clear, win_acc, win_loss;

  assign exp_bit = ^(hist_q & LFSR_POLYNOMIAL);
  assign mis     = din ^ exp_bit;

  lfsr_checker_win #(
    .LOSS_WINDOW (LOSS_WINDOW),
    .LOSS_THRESH (LOSS_THRESH)
  ) u_win (
    .clk   (clk),
    .reset (reset),
    .clear (win_clear),
    .acc   (win_acc),
    .mis   (mis),
    .loss  (win_loss)
  );

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
`ifdef LFSR_CHECKER_BIT_CNT_EN
    bit_cnt_d = bit_cnt_q;
`endif
    win_clear = 1'b0;
    win_acc   = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
    end else if (resync) begin
      state_d   = ST_SEED;
      fill_d    = '0;
      match_d   = '0;
      win_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_SEED;
          fill_d    = '0;
          match_d   = '0;
          win_clear = 1'b1;
        end
        ST_SEED: begin
          if (din_vld) begin
            hist_d = {hist_q[LFSR_WIDTH-2:0], din};
            if (fill_q == FW'(LFSR_WIDTH - 1)) begin
              state_d = ST_LOCKING;
              fill_d  = '0;
              match_d = '0;
            end else begin
              fill_d = fill_q + FW'(1);
            end
          end
        end
        ST_LOCKING: begin
          if (din_vld) begin
            hist_d = {hist_q[LFSR_WIDTH-2:0], din};
            if (!mis) begin
              if (match_q == MW'(LOCK_COUNT - 1)) begin
                state_d = ST_LOCKED;
                match_d = '0;
              end else begin
                match_d = match_q + MW'(1);
              end
            end else begin
              state_d   = ST_SEED;
              fill_d    = '0;
              match_d   = '0;
              win_clear = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (din_vld) begin
            win_acc = 1'b1;
            // Free-run on the prediction so one channel error counts once.
            hist_d  = {hist_q[LFSR_WIDTH-2:0], exp_bit};
`ifdef LFSR_CHECKER_BIT_CNT_EN
            if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 32'd1;
`endif
            if (mis) begin
              err_d = 1'b1;
              if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
            end
            if (win_loss) begin
              state_d   = ST_SEED;
              fill_d    = '0;
              match_d   = '0;
              win_clear = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (clr) begin
      err_cnt_d = '0;
`ifdef LFSR_CHECKER_BIT_CNT_EN
      bit_cnt_d = '0;
`endif
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
`ifdef LFSR_CHECKER_BIT_CNT_EN
      bit_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
`ifdef LFSR_CHECKER_BIT_CNT_EN
      bit_cnt_q <= bit_cnt_d;
`endif
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`ifdef LFSR_CHECKER_BIT_CNT_EN
  assign bit_cnt = bit_cnt_q;
`else
  assign bit_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed bench for lfsr_checker with default parameters.
// A local generator (x[n] = x[n-11] ^ x[n-2], matching tap mask
// 11'b10000000010) supplies the stream; single bits are inverted to inject
// channel errors.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset, en, din, din_vld, resync, clr;
  logic        locked, err;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;

  logic [10:0] g = 11'h5a3;
  logic        seen;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .din     (din),
    .din_vld (din_vld),
    .resync  (resync),
    .clr     (clr),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt),
    .bit_cnt (bit_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bc(input string tag, input logic [31:0] exp);
`ifdef LFSR_CHECKER_BIT_CNT_EN
    chk(tag, bit_cnt, exp);
`else
    chk({tag, "_tied"}, bit_cnt, 32'd0);
`endif
  endtask

  // Offer the next generator bit (optionally inverted), then sample 1 ns
  // after the edge that took it.
  task automatic drive(input logic flip);
    logic b;
    b       = g[10] ^ g[1];
    g       = {g[9:0], b};
    din     = b ^ flip;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_clean(input int n);
    seen = 1'b0;
    repeat (n) begin
      drive(1'b0);
      seen = seen | err;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b0; din = 1'b0; din_vld = 1'b0; resync = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk_bc("rst_bit_cnt", 32'd0);
    reset = 1'b0;

    // First acquisition: IDLE cycle + 11 seed + 16 matching bits.
    en = 1'b1;
    run_clean(27);
    chk("acq_not_yet", {31'd0, locked}, 32'd0);
    chk("acq_no_err", {31'd0, seen}, 32'd0);
    drive(1'b0);
    chk("acq_locked", {31'd0, locked}, 32'd1);
    chk_bc("acq_bit_cnt0", 32'd0);
    run_clean(10);
    chk_bc("bit_cnt_10", 32'd10);
    chk("clean_no_err", {31'd0, seen}, 32'd0);

    // Single channel error.
    drive(1'b1);
    chk("one_err_pulse", {31'd0, err}, 32'd1);
    chk("one_err_cnt", {16'd0, err_cnt}, 32'd1);
    chk("one_err_locked", {31'd0, locked}, 32'd1);
    run_clean(60);
    chk("no_followon", {31'd0, seen}, 32'd0);
    chk("one_err_cnt_hold", {16'd0, err_cnt}, 32'd1);
    chk_bc("bit_cnt_71", 32'd71);

    // clr with a clean accepted bit.
    clr = 1'b1;
    drive(1'b0);
    clr = 1'b0;
    chk("clr_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk_bc("clr_bit_cnt", 32'd0);

    // Four errors in one window -> loss after the fourth.
    drive(1'b1); drive(1'b1); drive(1'b1);
    chk("burst3_locked", {31'd0, locked}, 32'd1);
    chk("burst3_err_cnt", {16'd0, err_cnt}, 32'd3);
    drive(1'b1);
    chk("burst4_unlocked", {31'd0, locked}, 32'd0);
    chk("burst4_err", {31'd0, err}, 32'd1);
    chk("burst4_err_cnt", {16'd0, err_cnt}, 32'd4);
    chk_bc("burst4_bit_cnt", 32'd4);
    run_clean(26);
    chk("relock_not_yet", {31'd0, locked}, 32'd0);
    drive(1'b0);
    chk("relock", {31'd0, locked}, 32'd1);
    chk("relock_err_cnt", {16'd0, err_cnt}, 32'd4);

    // clr together with a mismatch: increment lost.
    clr = 1'b1;
    drive(1'b1);
    clr = 1'b0;
    chk("clrmis_err", {31'd0, err}, 32'd1);
    chk("clrmis_err_cnt", {16'd0, err_cnt}, 32'd0);

    // resync while locked.
    resync = 1'b1;
    drive(1'b0);
    resync = 1'b0;
    chk("resync_unlocked", {31'd0, locked}, 32'd0);
    run_clean(26);
    chk("resync_not_yet", {31'd0, locked}, 32'd0);
    drive(1'b0);
    chk("resync_relock", {31'd0, locked}, 32'd1);

    // Mismatch during LOCKING returns to SEED.
    resync = 1'b1;
    drive(1'b0);
    resync = 1'b0;
    run_clean(16);
    drive(1'b1);
    chk("locking_mis_err", {31'd0, err}, 32'd0);
    chk("locking_mis_locked", {31'd0, locked}, 32'd0);
    chk("locking_mis_err_cnt", {16'd0, err_cnt}, 32'd0);
    run_clean(26);
    chk("locking_reseed_not_yet", {31'd0, locked}, 32'd0);
    drive(1'b0);
    chk("locking_reseed_lock", {31'd0, locked}, 32'd1);

    drive(1'b1); drive(1'b0); drive(1'b1);
    chk("two_err_cnt", {16'd0, err_cnt}, 32'd2);
    chk("two_err_locked", {31'd0, locked}, 32'd1);

    // en=0 in the middle of SEED.
    resync = 1'b1;
    drive(1'b0);
    resync = 1'b0;
    run_clean(5);
    en = 1'b0;
    run_clean(3);
    chk("en0_locked", {31'd0, locked}, 32'd0);
    chk("en0_err_cnt", {16'd0, err_cnt}, 32'd2);
    en = 1'b1;
    run_clean(27);
    chk("en1_not_yet", {31'd0, locked}, 32'd0);
    drive(1'b0);
    chk("en1_locked", {31'd0, locked}, 32'd1);
    chk("en1_err_cnt", {16'd0, err_cnt}, 32'd2);

    // Asynchronous reset while locked with err_cnt=5.
    drive(1'b1); drive(1'b0); drive(1'b1); drive(1'b0); drive(1'b1);
    chk("pre_rst_err_cnt", {16'd0, err_cnt}, 32'd5);
    chk("pre_rst_locked", {31'd0, locked}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk_bc("arst_bit_cnt", 32'd0);
    #3;
    reset = 1'b0;
    run_clean(27);
    chk("post_rst_not_yet", {31'd0, locked}, 32'd0);
    drive(1'b0);
    chk("post_rst_locked", {31'd0, locked}, 32'd1);
    chk("post_rst_err_cnt", {16'd0, err_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial PRBS checker that receives the bit stream produced by the team's LFSR generator and reports whether it is synchronized, plus per-bit and accumulated error counts. It self-seeds from the incoming data, needs no seed parameter, and tolerates mid-stream reloads of the generator by losing and re-acquiring lock. It sits at the receive end of the serial link, one bit per qualified clock, and feeds BER-monitoring logic.

## Interface
- LFSR_WIDTH, 11, width of the checker's history register; must equal the generator's width.
- LFSR_POLYNOMIAL, 11'b10000000010, tap mask; must equal the generator's polynomial.
- LOCK_COUNT, 16, consecutive matching bits required after seeding to declare lock (≥1).
- LOSS_WINDOW, 64, length in accepted bits of the loss-detection window while locked.
- LOSS_THRESH, 4, errors within one window that force loss of lock (1..LOSS_WINDOW).
- ERR_CNT_WIDTH, 16, width of the saturating error counter.
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  enables the checker; low returns it to IDLE.
- din  input  1  received serial bit.
- din_vld  input  1  din is accepted on any cycle with en=1 and din_vld=1.
- resync  input  1  single-cycle request to discard lock and re-seed.
- clr  input  1  synchronous clear of err_cnt and bit_cnt.
- locked  output  1  checker is synchronized.
- err  output  1  one-cycle pulse for each mismatching accepted bit while LOCKED.
- err_cnt  output  ERR_CNT_WIDTH  saturating count of mismatches while LOCKED.
- bit_cnt  output  32  saturating count of bits accepted while LOCKED.

## Operation
- Recurrence: hist[0] is the most recent history bit. expected = XOR of hist[i] for every i where LFSR_POLYNOMIAL[i]=1. A generator stream with output taken from its MSB satisfies din = expected.
- States: IDLE, SEED, LOCKING, LOCKED.
- IDLE: no shifting. Goes to SEED when en=1.
- SEED: each accepted bit shifts din into hist. After LFSR_WIDTH accepted bits, goes to LOCKING with the match counter at 0.
- LOCKING: each accepted bit is compared with expected, and din is shifted into hist. A match increments the match counter; the LOCK_COUNT-th consecutive match moves to LOCKED. A mismatch returns to SEED with the fill count at 0. No err pulses and no counting occur in this state.
- LOCKED: hist shifts in expected, not din, so the checker free-runs and each channel error is counted exactly once. A mismatch pulses err and increments err_cnt and the window error count. bit_cnt increments on every accepted bit.
- Loss window: a window counter counts accepted bits. When it reaches LOSS_WINDOW it wraps, and the window error count clears. If the window error count reaches LOSS_THRESH, the state goes to SEED and locked falls.
- Entering SEED from any state clears the fill, match and window counters. hist is not cleared.
- en=0 from any state goes to IDLE. Counters and err_cnt/bit_cnt are held.
- resync=1 with en=1 goes to SEED from any state. It has priority over bit processing in the same cycle, and the bit offered in that cycle is discarded.
- clr=1 zeroes err_cnt and bit_cnt. An increment in the same cycle is lost, so the counters read 0 afterwards.
- Both counters saturate at all-ones and never wrap.

## Timing
- Reset values: state=IDLE, hist=0, locked=0, err=0, err_cnt=0, bit_cnt=0, all internal counters 0.
- All outputs are registered.
- err is high in the cycle after the offending bit is accepted.
- locked rises in the cycle after the LOCK_COUNT-th matching bit is accepted, and falls in the cycle after the bit that reaches LOSS_THRESH, or after resync or en deassertion.
- With continuous din_vld, the first possible locked=1 is LFSR_WIDTH+LOCK_COUNT accepted bits plus one cycle after en rises (plus the IDLE→SEED cycle).
- Throughput: one bit per clock. There is no backpressure.

## Configuration
- LFSR_CHECKER_BIT_CNT_EN defined: the 32-bit bit_cnt register is implemented as described.
- LFSR_CHECKER_BIT_CNT_EN undefined: no bit_cnt register is built and bit_cnt is tied to 0. The port remains present.

## Structure
- The shared package lfsr_pkg holds:
  - the checker state enum (2 bits: IDLE, SEED, LOCKING, LOCKED);
  - the default polynomial and width constants, shared with the generator.
- Sub-module lfsr_checker_win contains the loss-window counter, the window error counter and the threshold compare. Its output is a single loss pulse to the main FSM.

## Test plan
- Defaults, clean generator stream, din_vld=1 continuously → locked rises 28 cycles after en (1 IDLE + 11 SEED + 16 LOCKING); err stays 0; bit_cnt increments once per cycle.
- After lock, invert one bit → exactly one err pulse the next cycle; err_cnt=1; locked stays 1; no follow-on errors.
- After lock, invert 4 bits within 64 → locked=0 the cycle after the 4th; err_cnt=4; re-lock 27 accepted bits later.
- During LOCKING, invert a bit → back to SEED; locked stays 0 and err_cnt stays 0.
- resync in LOCKED, clr together with a mismatch, and en=0 mid-SEED → respectively SEED, counters 0, IDLE with counts held.
- Assert reset while LOCKED with err_cnt=5 → all outputs 0 immediately, asynchronously; normal re-acquisition after release.
